// File: rtl/game_event_logger_if.sv
// rtl/game_event_logger_if.sv - record stream between the event logger and its consumer
interface game_event_logger_if #(
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/game_event_logger.sv
// rtl/game_event_logger.sv - timestamps game-state events into a show-ahead FIFO with tallies
module game_event_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 12,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     win,
    input  logic                     los,
    input  logic                     gameover,
    input  logic [1:0]               who,
    input  logic                     log_en,
    input  logic                     clr,
    game_event_logger_if.master      out_if,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         win_matches,
    output logic [CNT_W-1:0]         loss_matches
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = TS_W + 4;
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [TS_W-1:0]  r_ts;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_loss_cnt;

    logic             w_event;
    logic [1:0]       w_type;
    logic [1:0]       w_who;
    logic [REC_W-1:0] w_rec;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // gameover masks a coincident win/los so only one record is produced per cycle
    always_comb begin
        w_type = 2'b00;
        w_who  = 2'b00;
        if (gameover) begin
            w_type = 2'b11;
            w_who  = who;
        end else if (win) begin
            w_type = 2'b10;
        end else if (los) begin
            w_type = 2'b01;
        end
    end

    assign w_event = gameover | win | los;
    assign w_rec   = {w_type, w_who, r_ts};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = ~w_empty & out_if.out_ready;
    assign w_push  = w_event & log_en & (~w_full | w_pop);
    assign w_drop  = w_event & log_en & w_full & ~w_pop;

    assign out_if.out_valid = ~w_empty;
    assign out_if.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fill_level       = r_count;
    assign overflow         = r_overflow;
    assign drop_cnt         = r_drop_cnt;
    assign win_matches      = r_win_cnt;
    assign loss_matches     = r_loss_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_win_cnt  <= '0;
            r_loss_cnt <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_win_cnt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);

            if (w_push) begin
                r_mem[r_wr_ptr] <= w_rec;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != CNT_MAX) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end

            // tallies follow every logged gameover cycle, even when its record is dropped
            if (gameover && log_en) begin
                if (who == 2'b10 && r_win_cnt != CNT_MAX)  r_win_cnt  <= r_win_cnt + CNT_W'(1);
                if (who == 2'b01 && r_loss_cnt != CNT_MAX) r_loss_cnt <= r_loss_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_game_event_logger.sv
// tb/tb_game_event_logger.sv - scoreboard bench for game_event_logger
module tb_game_event_logger;
    localparam int DEPTH = 8;
    localparam int TS_W  = 12;
    localparam int CNT_W = 8;
    localparam int RW    = TS_W + 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic win = 1'b0, los = 1'b0, gameover = 1'b0, log_en = 1'b1, clr = 1'b0;
    logic [1:0] who = 2'b00;
    logic [$clog2(DEPTH):0] fill_level;
    logic overflow;
    logic [CNT_W-1:0] drop_cnt, win_matches, loss_matches;

    game_event_logger_if #(.DATA_W(RW)) u_if ();

    game_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .win(win), .los(los), .gameover(gameover),
        .who(who), .log_en(log_en), .clr(clr), .out_if(u_if.master),
        .fill_level(fill_level), .overflow(overflow), .drop_cnt(drop_cnt),
        .win_matches(win_matches), .loss_matches(loss_matches)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ideal queue of records plus plain integer counters.
    logic [RW-1:0] exp_q[$];
    int m_cnt = 0, m_ts = 0, m_drop = 0, m_win = 0, m_loss = 0;
    bit m_ovf = 0;
    bit m_pop, m_ev;
    logic [1:0] m_type, m_who;

    task automatic model_clear();
        exp_q.delete();
        m_cnt = 0; m_ts = 0; m_drop = 0; m_win = 0; m_loss = 0; m_ovf = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
        end else if (clr) begin
            model_clear();
        end else begin
            m_pop = (m_cnt > 0) && u_if.out_ready;
            m_ev  = gameover || win || los;
            m_who = gameover ? who : 2'b00;
            m_type = gameover ? 2'b11 : (win ? 2'b10 : (los ? 2'b01 : 2'b00));
            if (m_ev && log_en) begin
                if (m_cnt < DEPTH || m_pop) begin
                    exp_q.push_back({m_type, m_who, TS_W'(m_ts)});
                    m_cnt = m_cnt + 1;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop = m_drop + 1;
                end
            end
            if (m_pop) m_cnt = m_cnt - 1;
            if (gameover && log_en && who == 2'b10 && m_win < 255) m_win = m_win + 1;
            if (gameover && log_en && who == 2'b01 && m_loss < 255) m_loss = m_loss + 1;
            m_ts = (m_ts + 1) % 4096;
        end
    end

    // Monitor: mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("out_valid", 32'(u_if.out_valid), 32'(m_cnt > 0));
            chk("fill_level", 32'(fill_level), 32'(m_cnt));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("win_matches", 32'(win_matches), 32'(m_win));
            chk("loss_matches", 32'(loss_matches), 32'(m_loss));
            if (u_if.out_valid && exp_q.size() > 0)
                chk("out_data", 32'(u_if.out_data), 32'(exp_q[0]));
            if (u_if.out_valid && u_if.out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        win = 0; los = 0; gameover = 0; who = 2'b00; clr = 0; log_en = 1;
    endtask

    task automatic do_clr();
        idle_inputs();
        clr = 1;
        step();
        clr = 0;
    endtask

    initial begin
        u_if.out_ready = 1'b0;
        step(2);
        chk("reset_valid", 32'(u_if.out_valid), 32'd0);
        chk("reset_data", 32'(u_if.out_data), 32'd0);
        reset = 1'b1;

        // win held for 3 cycles, sampled at timestamps 5,6,7
        step(5);
        chk("pre_event_valid", 32'(u_if.out_valid), 32'd0);
        win = 1;
        step();
        chk("valid_latency", 32'(u_if.out_valid), 32'd1);
        step(2);
        win = 0;
        chk("t1_fill", 32'(fill_level), 32'd3);
        chk("t1_head", 32'(u_if.out_data), 32'h8005);
        u_if.out_ready = 1;
        step(4);
        u_if.out_ready = 0;

        // fill and overflow
        do_clr();
        los = 1;
        step(10);
        los = 0;
        chk("t2_fill", 32'(fill_level), 32'd8);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_drop", 32'(drop_cnt), 32'd2);
        u_if.out_ready = 1;
        step(8);
        chk("t2_drained", 32'(fill_level), 32'd0);

        // full FIFO with coincident push and pop
        u_if.out_ready = 0;
        do_clr();
        los = 1;
        step(8);
        u_if.out_ready = 1;
        step();
        los = 0;
        chk("t3_fill", 32'(fill_level), 32'd8);
        chk("t3_drop", 32'(drop_cnt), 32'd0);
        step(9);
        u_if.out_ready = 0;

        // gameover beats a coincident win
        do_clr();
        gameover = 1; who = 2'b10; win = 1;
        step();
        idle_inputs();
        chk("t4_fill", 32'(fill_level), 32'd1);
        chk("t4_head", 32'(u_if.out_data), 32'hE000);
        chk("t4_win", 32'(win_matches), 32'd1);

        // clr from a busy state
        do_clr();
        gameover = 1; who = 2'b10;
        step(3);
        idle_inputs();
        los = 1;
        step(7);
        los = 0;
        u_if.out_ready = 1;
        step(3);
        u_if.out_ready = 0;
        chk("t5_fill", 32'(fill_level), 32'd5);
        chk("t5_ovf", 32'(overflow), 32'd1);
        chk("t5_win", 32'(win_matches), 32'd3);
        do_clr();
        chk("t5_clr_fill", 32'(fill_level), 32'd0);
        chk("t5_clr_valid", 32'(u_if.out_valid), 32'd0);
        chk("t5_clr_ovf", 32'(overflow), 32'd0);
        chk("t5_clr_win", 32'(win_matches), 32'd0);

        // asynchronous reset mid-drain
        los = 1;
        step(6);
        los = 0;
        u_if.out_ready = 1;
        step(2);
        #1 reset = 0;
        #1;
        chk("arst_valid", 32'(u_if.out_valid), 32'd0);
        chk("arst_fill", 32'(fill_level), 32'd0);
        chk("arst_data", 32'(u_if.out_data), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        step(2);
        reset = 1;
        u_if.out_ready = 0;

        // timestamp wrap
        do_clr();
        for (int i = 0; i < 5000 && m_ts != 4095; i++) step();
        chk("wrap_reach", 32'(m_ts), 32'd4095);
        win = 1;
        step(2);
        win = 0;
        chk("wrap_head", 32'(u_if.out_data), 32'h8FFF);
        chk("wrap_fill", 32'(fill_level), 32'd2);
        u_if.out_ready = 1;
        step(3);

        // drop counter saturation
        u_if.out_ready = 0;
        do_clr();
        los = 1;
        step(DEPTH + 300);
        los = 0;
        chk("sat_drop", 32'(drop_cnt), 32'd255);

        // randomized traffic
        do_clr();
        for (int i = 0; i < 3000; i++) begin
            gameover = ($urandom_range(0, 9) == 0);
            win      = ($urandom_range(0, 3) == 0);
            los      = ($urandom_range(0, 3) == 0);
            who      = 2'($urandom_range(0, 3));
            log_en   = ($urandom_range(0, 7) != 0);
            clr      = ($urandom_range(0, 299) == 0);
            u_if.out_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        idle_inputs();
        u_if.out_ready = 1;
        step(DEPTH + 2);
        chk("final_empty", 32'(fill_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/game_event_logger.md
Name: game_event_logger

Overview:
- Downstream consumer of the game-state stage. Samples its win, los, gameover and who outputs every clock and turns each asserted event into a timestamped record.
- Records are buffered in a show-ahead FIFO and drained through a valid/ready interface by a host or display stage.
- Keeps per-match tallies (winner/loser gameovers) and a sticky overflow indication with a drop counter.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
TS_W, 12, timestamp width in bits; record width is TS_W+4
CNT_W, 8, width of the tally and drop counters; counters saturate

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset; 0 = reset asserted
win  in  1  winner level from the game-state stage
los  in  1  loser level from the game-state stage
gameover  in  1  gameover level from the game-state stage
who  in  2  01 = loser reached 15, 10 = winner reached 15
log_en  in  1  1 = events are captured; 0 = events are ignored, no drop counted
clr  in  1  synchronous clear of FIFO, flags, counters and timestamp
out_valid  out  1  FIFO non-empty
out_data  out  TS_W+4  head record: [TS_W+3:TS_W+2] type, [TS_W+1:TS_W] who, [TS_W-1:0] timestamp
out_ready  in  1  consumer accepts the head record when out_valid & out_ready
fill_level  out  log2(DEPTH)+1  number of stored records
overflow  out  1  sticky: at least one event was dropped because the FIFO was full
drop_cnt  out  CNT_W  number of dropped events, saturating
win_matches  out  CNT_W  gameovers with who=10, saturating
loss_matches  out  CNT_W  gameovers with who=01, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; out_valid=0, out_data=0, fill_level=0.
  - overflow=0, drop_cnt=0, win_matches=0, loss_matches=0.
  - Timestamp counter=0.
- clr=1 (synchronous, highest priority after reset): same state as reset at the next edge. A coincident pop or event is discarded and not counted.
- Timestamp: free-running TS_W-bit counter, +1 every cycle, wraps from all-ones to 0. A record stores the counter value of the cycle in which the event was sampled.
- Event selection: at most one record per cycle, by priority gameover > win > los.
  - type: 11 = gameover, 10 = win, 01 = loss.
  - The who field holds input who for gameover records and 00 otherwise.
  - A win or los sampled in the same cycle as gameover is not logged.
- Level-sampled: every cycle with the input high produces a record. A level held for N cycles yields N records, matching the per-cycle counting of the game-state stage.
- Tallies: updated on every sampled gameover cycle with log_en=1, independent of FIFO space. who=00 or 11 updates neither tally.
- FIFO:
  - Show-ahead: out_data is the head entry whenever out_valid=1. out_data holds its value while out_valid=1 and out_ready=0.
  - Push when event & log_en & (not full, or pop in the same cycle).
  - Push into an empty FIFO: out_valid=1 on the following cycle (latency 1).
  - Push and pop in the same cycle: fill_level unchanged, including when the FIFO is full.
  - Pop on an empty FIFO: no effect.
  - fill_level counts 0..DEPTH.
- Overflow: an event with log_en=1, FIFO full and no pop is dropped.
  - overflow is set and stays set until reset or clr.
  - drop_cnt increments and saturates at 2^CNT_W-1.
- Reset asserted mid-transfer clears everything immediately. In-flight records are lost and no partial state remains.

Test Plan:
- Reset, then win=1 for 3 cycles (timestamps 5,6,7), out_ready=0 -> fill_level=3; head record type=10, who=00, ts=5; out_valid rises one cycle after the first event.
- Fill the FIFO with 8 los events, then 2 more los with out_ready=0 -> fill_level=8, overflow=1, drop_cnt=2; drain 8 records in order with types all 01.
- With the FIFO full, one los event while out_ready=1 -> record accepted, fill_level stays 8, drop_cnt unchanged.
- gameover=1, who=10, win=1 in the same cycle -> one record type=11, who=10; win_matches=1; no win record.
- Timestamp wrap with TS_W=12: event at ts=4095 and the next cycle -> records carry ts=4095 then ts=0.
- clr=1 with fill_level=5, overflow=1 and win_matches=3 -> next cycle all zero, out_valid=0. Then assert reset=0 mid-drain -> outputs zero immediately, without waiting for a clock edge.
